// File: rtl/regfile_writeback_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// regfile_writeback_ctrl_pkg
// Shared definitions for the register-file writeback controller slice.
//   addr_width() : register address width derived from the register count
//   REG_ZERO     : index of the hard-wired zero register (x0)
//   grant_t      : which requester wins the write port in a given cycle
// ----------------------------------------------------------------------------
package regfile_writeback_ctrl_pkg;

    localparam int REG_ZERO = 0;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_LD   = 2'd1,
        GNT_ALU  = 2'd2
    } grant_t;

    // A single-register file would give $clog2 == 0; keep at least one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// ----------------------------------------------------------------------------
// regfile_scoreboard
// Pending-load scoreboard: one bit per architectural register, set when a
// load issues and cleared when its data is written back.
// Ports:
//   clk, reset_l              clock, synchronous active-low reset
//   set_en, set_rd            accepted load issue reserving set_rd
//   clr_en, clr_rd            accepted load writeback releasing clr_rd
//   issue_rd, issue_ready     WAW check for the load trying to issue
//   inflight_we/inflight_addr registered write not yet in the register file
//   rs1/rs2, rs1_busy/rs2_busy source operand hazard lookups
// ----------------------------------------------------------------------------
module regfile_scoreboard
    import regfile_writeback_ctrl_pkg::*;
#(
    parameter int MEMORY_DEPTH = 32,
    parameter int AW           = addr_width(MEMORY_DEPTH)
) (
    input  logic          clk,
    input  logic          reset_l,
    input  logic          set_en,
    input  logic [AW-1:0] set_rd,
    input  logic          clr_en,
    input  logic [AW-1:0] clr_rd,
    input  logic [AW-1:0] issue_rd,
    output logic          issue_ready,
    input  logic          inflight_we,
    input  logic [AW-1:0] inflight_addr,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          rs1_busy,
    output logic          rs2_busy
);

    logic [MEMORY_DEPTH-1:0] pending;

    // Issue is refused while its rd is still pending, so a set and a clear
    // never target the same bit in one cycle; x0 is forced clear last.
    always_ff @(posedge clk) begin
        if (!reset_l) begin
            pending <= '0;
        end else begin
            if (clr_en) begin
                pending[clr_rd] <= 1'b0;
            end
            if (set_en) begin
                pending[set_rd] <= 1'b1;
            end
            pending[REG_ZERO] <= 1'b0;
        end
    end

    // The registered write is one cycle away from the register file, so a
    // source matching it is still busy.
    always_comb begin
        issue_ready = !pending[issue_rd];
        rs1_busy    = (rs1 != AW'(REG_ZERO)) &&
                      (pending[rs1] || (inflight_we && (inflight_addr == rs1)));
        rs2_busy    = (rs2 != AW'(REG_ZERO)) &&
                      (pending[rs2] || (inflight_we && (inflight_addr == rs2)));
    end

endmodule

// File: rtl/regfile_writeback_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_writeback_ctrl
// Arbitrates ALU and load-return writebacks onto the register file write port
// (one-cycle registered latency) and tracks outstanding loads for hazards.
// Ports:
//   clk_i, reset_l_i                      clock, synchronous active-low reset
//   alu_valid_i/alu_ready_o/alu_rd_i/alu_data_i   ALU writeback channel
//   ld_valid_i/ld_ready_o/ld_rd_i/ld_data_i       load-return writeback channel
//   issue_valid_i/issue_ready_o/issue_rd_i        load issue reservation
//   rs1_i/rs2_i, rs1_busy_o/rs2_busy_o            decode hazard queries
//   rf_addr_o/rf_data_o/rf_we_o                   register file write port
// ----------------------------------------------------------------------------
module regfile_writeback_ctrl
    import regfile_writeback_ctrl_pkg::*;
#(
    parameter  int DATA_WIDTH   = 32,
    parameter  int MEMORY_DEPTH = 32,
    parameter  int STARVE_LIMIT = 4,
    localparam int AW           = addr_width(MEMORY_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  reset_l_i,
    input  logic                  alu_valid_i,
    output logic                  alu_ready_o,
    input  logic [AW-1:0]         alu_rd_i,
    input  logic [DATA_WIDTH-1:0] alu_data_i,
    input  logic                  ld_valid_i,
    output logic                  ld_ready_o,
    input  logic [AW-1:0]         ld_rd_i,
    input  logic [DATA_WIDTH-1:0] ld_data_i,
    input  logic                  issue_valid_i,
    output logic                  issue_ready_o,
    input  logic [AW-1:0]         issue_rd_i,
    input  logic [AW-1:0]         rs1_i,
    input  logic [AW-1:0]         rs2_i,
    output logic                  rs1_busy_o,
    output logic                  rs2_busy_o,
    output logic [AW-1:0]         rf_addr_o,
    output logic [DATA_WIDTH-1:0] rf_data_o,
    output logic                  rf_we_o
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;
    logic          starve_override;
    logic          sb_issue_ready;
    grant_t        grant;

    // Load wins by default; once the ALU has been denied STARVE_LIMIT times
    // in a row it takes one slot and the load is held off for that cycle.
    // The two grants are mutually exclusive by construction.
    always_comb begin
        starve_override = (starve_cnt == SW'(STARVE_LIMIT));
        alu_ready_o     = reset_l_i && (!ld_valid_i || starve_override);
        ld_ready_o      = reset_l_i && !starve_override;
        issue_ready_o   = reset_l_i && sb_issue_ready;
        grant           = GNT_NONE;
        if (ld_valid_i && ld_ready_o) begin
            grant = GNT_LD;
        end else if (alu_valid_i && alu_ready_o) begin
            grant = GNT_ALU;
        end
    end

    // Counts consecutive cycles the ALU waits; any ALU transfer or idle ALU
    // restarts the count.
    always_ff @(posedge clk_i) begin
        if (!reset_l_i) begin
            starve_cnt <= '0;
        end else if (!alu_valid_i || alu_ready_o) begin
            starve_cnt <= '0;
        end else if (!starve_override) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Write port: address and data are captured for x0 too, but the enable
    // stays low so the zero register is never written.
    always_ff @(posedge clk_i) begin
        if (!reset_l_i) begin
            rf_we_o   <= 1'b0;
            rf_addr_o <= '0;
            rf_data_o <= '0;
        end else begin
            case (grant)
                GNT_LD: begin
                    rf_we_o   <= (ld_rd_i != AW'(REG_ZERO));
                    rf_addr_o <= ld_rd_i;
                    rf_data_o <= ld_data_i;
                end
                GNT_ALU: begin
                    rf_we_o   <= (alu_rd_i != AW'(REG_ZERO));
                    rf_addr_o <= alu_rd_i;
                    rf_data_o <= alu_data_i;
                end
                default: begin
                    rf_we_o <= 1'b0;
                end
            endcase
        end
    end

    regfile_scoreboard #(
        .MEMORY_DEPTH (MEMORY_DEPTH),
        .AW           (AW)
    ) u_scoreboard (
        .clk           (clk_i),
        .reset_l       (reset_l_i),
        .set_en        (issue_valid_i && issue_ready_o),
        .set_rd        (issue_rd_i),
        .clr_en        (grant == GNT_LD),
        .clr_rd        (ld_rd_i),
        .issue_rd      (issue_rd_i),
        .issue_ready   (sb_issue_ready),
        .inflight_we   (rf_we_o),
        .inflight_addr (rf_addr_o),
        .rs1           (rs1_i),
        .rs2           (rs2_i),
        .rs1_busy      (rs1_busy_o),
        .rs2_busy      (rs2_busy_o)
    );

endmodule

// File: tb/tb_regfile_writeback_ctrl.sv
// ----------------------------------------------------------------------------
// tb_regfile_writeback_ctrl
// Directed scenarios for the writeback controller with hand-computed
// expectations; each scenario task checks its own results inline.
// ----------------------------------------------------------------------------
module tb_regfile_writeback_ctrl;

    logic        clk = 1'b0;
    logic        reset_l;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid, ld_ready;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_rd;
    logic [4:0]  rs1, rs2;
    logic        rs1_busy, rs2_busy;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;
    logic        rf_we;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    regfile_writeback_ctrl #(
        .DATA_WIDTH   (32),
        .MEMORY_DEPTH (32),
        .STARVE_LIMIT (4)
    ) dut (
        .clk_i         (clk),
        .reset_l_i     (reset_l),
        .alu_valid_i   (alu_valid),
        .alu_ready_o   (alu_ready),
        .alu_rd_i      (alu_rd),
        .alu_data_i    (alu_data),
        .ld_valid_i    (ld_valid),
        .ld_ready_o    (ld_ready),
        .ld_rd_i       (ld_rd),
        .ld_data_i     (ld_data),
        .issue_valid_i (issue_valid),
        .issue_ready_o (issue_ready),
        .issue_rd_i    (issue_rd),
        .rs1_i         (rs1),
        .rs2_i         (rs2),
        .rs1_busy_o    (rs1_busy),
        .rs2_busy_o    (rs2_busy),
        .rf_addr_o     (rf_addr),
        .rf_data_o     (rf_data),
        .rf_we_o       (rf_we)
    );

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        alu_rd      = 5'd0;
        alu_data    = 32'h0;
        ld_valid    = 1'b0;
        ld_rd       = 5'd0;
        ld_data     = 32'h0;
        issue_valid = 1'b0;
        issue_rd    = 5'd0;
        rs1         = 5'd0;
        rs2         = 5'd0;
    endtask

    task automatic test_reset();
        reset_l     = 1'b0;
        alu_valid   = 1'b1; alu_rd   = 5'd2; alu_data = 32'h1111_1111;
        ld_valid    = 1'b1; ld_rd    = 5'd3; ld_data  = 32'h2222_2222;
        issue_valid = 1'b1; issue_rd = 5'd4;
        rs1 = 5'd0; rs2 = 5'd0;
        cycle();
        cycle();
        checks++; if (alu_ready !== 1'b0) $display("[TB] FAIL reset_alu_ready got %0b expected 0", alu_ready); else passed++;
        checks++; if (ld_ready !== 1'b0) $display("[TB] FAIL reset_ld_ready got %0b expected 0", ld_ready); else passed++;
        checks++; if (issue_ready !== 1'b0) $display("[TB] FAIL reset_issue_ready got %0b expected 0", issue_ready); else passed++;
        checks++; if (rf_we !== 1'b0) $display("[TB] FAIL reset_rf_we got %0b expected 0", rf_we); else passed++;
        checks++; if (rf_addr !== 5'd0) $display("[TB] FAIL reset_rf_addr got %0d expected 0", rf_addr); else passed++;
        checks++; if (rf_data !== 32'h0) $display("[TB] FAIL reset_rf_data got %h expected 0", rf_data); else passed++;
        reset_l = 1'b1;
        idle();
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        checks++; if (alu_ready !== 1'b1) $display("[TB] FAIL first_alu_ready got %0b expected 1", alu_ready); else passed++;
        cycle();
        alu_valid = 1'b0;
        checks++; if (rf_we !== 1'b1) $display("[TB] FAIL first_rf_we got %0b expected 1", rf_we); else passed++;
        checks++; if (rf_addr !== 5'd5) $display("[TB] FAIL first_rf_addr got %0d expected 5", rf_addr); else passed++;
        checks++; if (rf_data !== 32'hDEADBEEF) $display("[TB] FAIL first_rf_data got %h expected deadbeef", rf_data); else passed++;
        cycle();
        checks++; if (rf_we !== 1'b0) $display("[TB] FAIL idle_rf_we got %0b expected 0", rf_we); else passed++;
        checks++; if (rf_addr !== 5'd5) $display("[TB] FAIL idle_rf_addr_hold got %0d expected 5", rf_addr); else passed++;
    endtask

    task automatic test_conflict();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hAAAA_0003;
        ld_valid  = 1'b1; ld_rd  = 5'd4; ld_data  = 32'hBBBB_0004;
        #1;
        checks++; if (ld_ready !== 1'b1) $display("[TB] FAIL conflict_ld_ready got %0b expected 1", ld_ready); else passed++;
        checks++; if (alu_ready !== 1'b0) $display("[TB] FAIL conflict_alu_ready got %0b expected 0", alu_ready); else passed++;
        cycle();
        ld_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd4) $display("[TB] FAIL conflict_ld_write got we=%0b addr=%0d expected we=1 addr=4", rf_we, rf_addr); else passed++;
        checks++; if (rf_data !== 32'hBBBB_0004) $display("[TB] FAIL conflict_ld_data got %h expected bbbb0004", rf_data); else passed++;
        #1;
        checks++; if (alu_ready !== 1'b1) $display("[TB] FAIL conflict_alu_ready_next got %0b expected 1", alu_ready); else passed++;
        cycle();
        alu_valid = 1'b0;
        checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd3) $display("[TB] FAIL conflict_alu_write got we=%0b addr=%0d expected we=1 addr=3", rf_we, rf_addr); else passed++;
        checks++; if (rf_data !== 32'hAAAA_0003) $display("[TB] FAIL conflict_alu_data got %h expected aaaa0003", rf_data); else passed++;
    endtask

    task automatic test_starvation();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hA11C_000B;
        ld_valid  = 1'b1; ld_rd  = 5'd10; ld_data  = 32'h10AD_000A;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (alu_ready !== 1'b0 || ld_ready !== 1'b1) $display("[TB] FAIL starve_wait%0d got alu_ready=%0b ld_ready=%0b expected 0/1", i, alu_ready, ld_ready); else passed++;
            cycle();
            checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd10) $display("[TB] FAIL starve_ld_write%0d got we=%0b addr=%0d expected we=1 addr=10", i, rf_we, rf_addr); else passed++;
        end
        #1;
        checks++; if (alu_ready !== 1'b1) $display("[TB] FAIL starve_override_alu got %0b expected 1", alu_ready); else passed++;
        checks++; if (ld_ready !== 1'b0) $display("[TB] FAIL starve_override_ld got %0b expected 0", ld_ready); else passed++;
        cycle();
        checks++; if (rf_addr !== 5'd11 || rf_data !== 32'hA11C_000B) $display("[TB] FAIL starve_alu_write got addr=%0d data=%h expected addr=11 data=a11c000b", rf_addr, rf_data); else passed++;
        alu_data = 32'hA11C_100B;
        #1;
        checks++; if (alu_ready !== 1'b0 || ld_ready !== 1'b1) $display("[TB] FAIL starve_counter_cleared got alu_ready=%0b ld_ready=%0b expected 0/1", alu_ready, ld_ready); else passed++;
        cycle();
        checks++; if (rf_addr !== 5'd10) $display("[TB] FAIL starve_ld_resumes got addr=%0d expected 10", rf_addr); else passed++;
        idle();
        cycle();
    endtask

    task automatic test_x0();
        idle();
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0BAD_F00D;
        #1;
        checks++; if (alu_ready !== 1'b1) $display("[TB] FAIL x0_alu_ready got %0b expected 1", alu_ready); else passed++;
        cycle();
        alu_valid = 1'b0;
        checks++; if (rf_we !== 1'b0) $display("[TB] FAIL x0_rf_we got %0b expected 0", rf_we); else passed++;
        checks++; if (rf_addr !== 5'd0 || rf_data !== 32'h0BAD_F00D) $display("[TB] FAIL x0_port_capture got addr=%0d data=%h expected addr=0 data=0badf00d", rf_addr, rf_data); else passed++;
        rs1 = 5'd0;
        #1;
        checks++; if (rs1_busy !== 1'b0) $display("[TB] FAIL x0_rs1_busy got %0b expected 0", rs1_busy); else passed++;
        cycle();
    endtask

    task automatic test_scoreboard();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd7;
        #1;
        checks++; if (issue_ready !== 1'b1) $display("[TB] FAIL sb_issue_ready got %0b expected 1", issue_ready); else passed++;
        cycle();
        issue_valid = 1'b0;
        rs1 = 5'd7; rs2 = 5'd8;
        #1;
        checks++; if (rs1_busy !== 1'b1) $display("[TB] FAIL sb_rs1_pending got %0b expected 1", rs1_busy); else passed++;
        checks++; if (rs2_busy !== 1'b0) $display("[TB] FAIL sb_rs2_free got %0b expected 0", rs2_busy); else passed++;
        checks++; if (issue_ready !== 1'b0) $display("[TB] FAIL sb_waw_stall got %0b expected 0", issue_ready); else passed++;
        issue_rd = 5'd0;
        #1;
        checks++; if (issue_ready !== 1'b1) $display("[TB] FAIL sb_issue_x0 got %0b expected 1", issue_ready); else passed++;
        issue_rd = 5'd7;
        ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h7777_0007;
        #1;
        checks++; if (ld_ready !== 1'b1 || rs1_busy !== 1'b1) $display("[TB] FAIL sb_ld_return got ld_ready=%0b busy=%0b expected 1/1", ld_ready, rs1_busy); else passed++;
        cycle();
        ld_valid = 1'b0;
        #1;
        checks++; if (rf_we !== 1'b1 || rf_addr !== 5'd7) $display("[TB] FAIL sb_ld_write got we=%0b addr=%0d expected we=1 addr=7", rf_we, rf_addr); else passed++;
        checks++; if (rs1_busy !== 1'b1) $display("[TB] FAIL sb_inflight_busy got %0b expected 1", rs1_busy); else passed++;
        checks++; if (issue_ready !== 1'b1) $display("[TB] FAIL sb_pending_cleared got %0b expected 1", issue_ready); else passed++;
        cycle();
        checks++; if (rs1_busy !== 1'b0) $display("[TB] FAIL sb_busy_released got %0b expected 0", rs1_busy); else passed++;
    endtask

    task automatic test_reset_midflight();
        idle();
        issue_valid = 1'b1; issue_rd = 5'd9;
        #1;
        checks++; if (issue_ready !== 1'b1) $display("[TB] FAIL mid_issue_ready got %0b expected 1", issue_ready); else passed++;
        cycle();
        issue_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd12; alu_data = 32'h5555_000C;
        cycle();
        alu_valid = 1'b0;
        rs1 = 5'd9; rs2 = 5'd12;
        #1;
        checks++; if (rf_we !== 1'b1 || rs1_busy !== 1'b1 || rs2_busy !== 1'b1) $display("[TB] FAIL mid_before_reset got we=%0b rs1_busy=%0b rs2_busy=%0b expected 1/1/1", rf_we, rs1_busy, rs2_busy); else passed++;
        reset_l = 1'b0;
        cycle();
        reset_l = 1'b1;
        #1;
        checks++; if (rf_we !== 1'b0 || rf_addr !== 5'd0) $display("[TB] FAIL mid_port_cleared got we=%0b addr=%0d expected we=0 addr=0", rf_we, rf_addr); else passed++;
        checks++; if (rs1_busy !== 1'b0) $display("[TB] FAIL mid_rs1_busy got %0b expected 0", rs1_busy); else passed++;
        checks++; if (rs2_busy !== 1'b0) $display("[TB] FAIL mid_rs2_busy got %0b expected 0", rs2_busy); else passed++;
        issue_rd = 5'd9;
        #1;
        checks++; if (issue_ready !== 1'b1) $display("[TB] FAIL mid_issue_after_reset got %0b expected 1", issue_ready); else passed++;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog_timeout got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        idle();
        reset_l = 1'b0;
        test_reset();
        test_conflict();
        test_starvation();
        test_x0();
        test_scoreboard();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/regfile_writeback_ctrl.md
Name: regfile_writeback_ctrl

Overview:
Writer-side controller for the core's register file. Arbitrates writeback requests from the ALU path and the load path and drives the register file write port (address, data, write enable) with a registered one-cycle latency. Keeps a pending-load scoreboard so the decode/issue stage can detect RAW and WAW hazards before reading source operands.

Parameters:
DATA_WIDTH, 32, width of a register and of the writeback data
MEMORY_DEPTH, 32, number of architectural registers; address width is $clog2(MEMORY_DEPTH)
STARVE_LIMIT, 4, consecutive ALU-denied cycles after which the ALU wins one arbitration

Ports:
clk_i  in  1  clock; all state updates on its rising edge
reset_l_i  in  1  reset, synchronous, active-low
alu_valid_i  in  1  ALU writeback request
alu_ready_o  out  1  ALU request accepted this cycle
alu_rd_i  in  AW  ALU destination register (AW = $clog2(MEMORY_DEPTH))
alu_data_i  in  DATA_WIDTH  ALU result
ld_valid_i  in  1  load-return writeback request
ld_ready_o  out  1  load request accepted this cycle
ld_rd_i  in  AW  load destination register
ld_data_i  in  DATA_WIDTH  load data
issue_valid_i  in  1  a load is issuing and reserves issue_rd_i
issue_ready_o  out  1  reservation accepted
issue_rd_i  in  AW  destination register of the issuing load
rs1_i, rs2_i  in  AW  source registers queried by decode
rs1_busy_o, rs2_busy_o  out  1  source operand not yet valid in the register file
rf_addr_o  out  AW  register file write address
rf_data_o  out  DATA_WIDTH  register file write data
rf_we_o  out  1  register file write enable

Behaviour:
- Reset: clk_i is the only clock; reset_l_i is synchronous and active-low. While reset_l_i=0 at a rising edge: rf_we_o=0, rf_addr_o=0, rf_data_o=0, every pending bit=0, starve counter=0. alu_ready_o, ld_ready_o and issue_ready_o are forced to 0 whenever reset_l_i=0. Reset asserted mid-operation discards any in-flight write and all reservations.
- Handshake: a transfer occurs when valid and ready are both 1 in the same cycle. Ready never depends on its own valid. Once raised, valid and its payload are held stable until accepted.
- Arbitration (combinational):
  - Load has priority: ld_ready_o=1.
  - alu_ready_o = !ld_valid_i OR starve_cnt==STARVE_LIMIT.
  - When the starve override is active, ld_ready_o=0 for that cycle.
- Starve counter: increments (saturating at STARVE_LIMIT) each cycle alu_valid_i=1 and alu_ready_o=0. Clears to 0 on an ALU transfer or when alu_valid_i=0.
- Write port (latency 1): on an accepted transfer, the next edge registers rf_addr_o=rd, rf_data_o=data, rf_we_o=(rd!=0). With no transfer, rf_we_o=0 next cycle and rf_addr_o/rf_data_o hold their values.
- Writes to x0 complete the handshake but never assert rf_we_o.
- Scoreboard: one pending bit per register; bit 0 is hard-wired to 0.
  - Accepted issue sets pending[issue_rd_i].
  - Accepted load writeback clears pending[ld_rd_i].
  - issue_ready_o = !pending[issue_rd_i] (WAW stall). issue_ready_o=1 when issue_rd_i=0, and no bit is set.
  - Simultaneous issue and load return to the same rd in one cycle: issue_ready_o is 0 that cycle (pending still set), so set/clear never collide.
- Busy query (combinational): rsN_busy_o = (rsN!=0) AND (pending[rsN] OR (rf_we_o AND rf_addr_o==rsN)). The in-flight registered write has not yet reached the register file, so it counts as busy.
- ALU writeback to a register with a pending load is legal at this block's level. It writes normally and leaves the pending bit unchanged. The issue stage prevents it.

Decomposition:
- Shared package: AW derivation, REG_ZERO constant (0), arbitration-grant encoding (GNT_NONE, GNT_LD, GNT_ALU).
- One natural sub-module: regfile_scoreboard. It holds the pending bits and provides set, clear, issue_ready and the two busy lookups.
- The arbiter and write-port registers stay in the top module.

Test Plan:
- Reset: hold reset_l_i=0 for 2 cycles with all valids=1 -> all readies=0, rf_we_o=0, rf_addr_o=0, rf_data_o=0. Release, then alu_valid_i=1, rd=5, data=32'hDEADBEEF -> next cycle rf_we_o=1, rf_addr_o=5, rf_data_o=32'hDEADBEEF.
- Conflict: ALU (rd=3) and load (rd=4) both valid -> load accepted first and written next cycle; ALU accepted the cycle after.
- Starvation: keep ld_valid_i=1 and alu_valid_i=1 continuously with STARVE_LIMIT=4 -> ALU accepted on the 5th cycle, ld_ready_o=0 that cycle, counter back to 0.
- x0 writes: ALU writeback with rd=0 -> alu_ready_o=1, rf_we_o stays 0. Query rs1_i=0 -> rs1_busy_o=0.
- Scoreboard: issue load rd=7 -> rs1_i=7 gives busy=1 and a second issue to rd=7 gives issue_ready_o=0. Load return rd=7 -> busy still 1 in the write cycle (in-flight), 0 the following cycle.
- Reset mid-flight: pending[9]=1 and a write in flight, then reset_l_i=0 for 1 cycle -> pending cleared, rf_we_o=0, rs1_i=9 gives busy=0.
